usr_seq: RTL and testbench
==========================

USR_SEQ -- requirements
Module: usr_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the data width of the controlled universal shift register.
REQ-002 SHALL have parameter CNT_W, default 3, giving the width of the shift-count field.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: a command is present.
REQ-006 SHALL have port cmd_ready, output, 1 bit: the controller accepts a command this cycle.
REQ-007 SHALL have port cmd_op, input, 2 bits: 00 load-only; 01 load then shift right; 10 load then shift left; 11 hold-delay.
REQ-008 SHALL have port cmd_data, input, WIDTH bits: the parallel load value.
REQ-009 SHALL have port cmd_count, input, CNT_W bits: the number of shift or hold cycles (0..7).
REQ-010 SHALL have port abort, input, 1 bit: synchronous cancel of the current command.
REQ-011 SHALL have port ctrl, output, 2 bits, to the register: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-012 SHALL have port d, output, WIDTH bits: the parallel data to the register.
REQ-013 SHALL have port q, input, WIDTH bits: the register output.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-015 SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-016 SHALL have port result, output, WIDTH bits: the q value captured at completion.

Function
REQ-017 SHALL implement states IDLE, LOAD, SHIFT, HOLD and DONE.
REQ-018 SHALL drive cmd_ready = (state==IDLE); the command is accepted on a clk edge where cmd_valid && cmd_ready.
REQ-019 SHALL register cmd_op, cmd_data and cmd_count on acceptance; later changes to the inputs SHALL have no effect on that command.
REQ-020 SHALL transition on acceptance to LOAD for op 00/01/10, and to HOLD for op 11.
REQ-021 SHALL, in LOAD, drive ctrl=11 and d=the latched data for exactly one cycle.
REQ-022 SHALL, after LOAD, go to DONE for op 00 or count=0, else to SHIFT.
REQ-023 SHALL, in SHIFT, drive ctrl=01 (op 01) or 10 (op 10) for exactly count consecutive cycles, then go to DONE.
REQ-024 SHALL, in HOLD, drive ctrl=00 for count cycles (count=0 skips directly to DONE), then go to DONE.
REQ-025 SHALL drive ctrl=00 in IDLE and DONE.
REQ-026 SHALL hold d at its last loaded value when not in LOAD.
REQ-027 SHALL, in DONE (one cycle), register result<=q at the exiting edge, assert done in the following cycle, and go to IDLE.
REQ-028 SHALL exhibit latency from the acceptance edge to the done-high cycle of: load ops 3+count cycles; op 00 exactly 3 cycles; op 11 2+count cycles.
REQ-029 SHALL keep the count down-counter at CNT_W bits, decrementing once per SHIFT/HOLD cycle, with no wrap below zero; the exit condition is a counter value of 1 in its last cycle.
REQ-030 SHALL honour done=1 concurrently with cmd_ready=1; a new command accepted in that cycle is legal.
REQ-031 SHALL, when abort=1 in any non-IDLE state, go to IDLE at the next edge, with ctrl=00 from that edge, no done, and result unchanged.
REQ-032 SHALL ignore abort in IDLE.
REQ-033 SHALL give abort priority over acceptance in the same cycle and ignore the command (cmd_ready is low outside IDLE, so this arises only via IDLE ignore).

Reset
REQ-034 SHALL, while reset is high, immediately force: state IDLE, ctrl=00, d=0, result=0, done=0, busy=0, counter=0, and cmd_ready=1 after release.
REQ-035 SHALL, on reset mid-command, discard the command with no done pulse after release.

Verification
REQ-036 SHALL verify: reset then op=01, data=1001, count=2 -> ctrl sequence 11,01,01,00; d=1001 during LOAD; done 5 cycles after acceptance; result=0010 (zero-fill register model).
REQ-037 SHALL verify: op=10, data=1001, count=1 -> ctrl 11,10,00; result=0010; done at cycle 4.
REQ-038 SHALL verify: op=00, data=0110 (any count) -> ctrl 11,00; result=0110; done at cycle 3.
REQ-039 SHALL verify: op=11, count=0 -> no load/shift, ctrl stays 00, result=prior q, done at cycle 2; with count=7, done at cycle 9.
REQ-040 SHALL verify: abort in the 2nd SHIFT cycle of a count=5 command -> IDLE next edge, ctrl=00, no done, result unchanged; and back-to-back command accepted in the done cycle runs correctly.
REQ-041 SHALL verify: async reset asserted mid-SHIFT -> outputs at reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/usr_seq.sv
// usr_seq: command sequencer that drives a universal shift register through load, shift and hold phases.
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset
//   cmd_valid  : command present
//   cmd_ready  : controller idle and able to accept a command
//   cmd_op     : 00 load, 01 load+shift right, 10 load+shift left, 11 hold-delay
//   cmd_data   : parallel load value
//   cmd_count  : number of shift/hold cycles
//   abort      : cancel the running command
//   ctrl       : register control (00 hold, 01 right, 10 left, 11 load)
//   d          : parallel data to the register
//   q          : register output
//   busy       : controller not idle
//   done       : one-cycle completion pulse
//   result     : q captured at completion
module usr_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [1:0]       ctrl,
  output logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, HOLD, DONE} state_t;
  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_dec;
  assign cnt_dec   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign d         = d_q;
  assign done      = done_q;
  assign result    = result_q;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    result_d = result_q;
    done_d   = 1'b0;
    ctrl     = 2'b00;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        cnt_d   = cmd_count;
        // a hold-delay never loads, so d keeps the last loaded value
        d_d     = (cmd_op == 2'b11) ? d_q : cmd_data;
        state_d = (cmd_op != 2'b11) ? LOAD : (cmd_count == '0) ? DONE : HOLD;
      end
      LOAD: begin
        ctrl    = 2'b11;
        state_d = (op_q == 2'b00 || cnt_q == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        ctrl    = op_q;
        cnt_d   = cnt_dec;
        state_d = (cnt_q <= 1) ? DONE : SHIFT;
      end
      HOLD: begin
        cnt_d   = cnt_dec;
        state_d = (cnt_q <= 1) ? DONE : HOLD;
      end
      DONE: begin
        result_d = q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort wins over everything outside IDLE: no capture, no pulse
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      result_d = result_q;
      done_d   = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      cnt_q    <= '0;
      d_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_usr_seq.sv
// tb_usr_seq: scoreboard bench for usr_seq with a zero-fill shift register model in the loop.
module tb_usr_seq;
  localparam int W = 4;
  localparam int C = 3;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0, q_m;
  logic [C-1:0] cmd_count = '0;
  logic cmd_ready, busy, done;
  logic [1:0] ctrl;
  logic [W-1:0] d, result, mon_exp, last_d = '0;
  logic [W-1:0] sb[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  usr_seq #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .abort(abort),
    .ctrl(ctrl), .d(d), .q(q_m), .busy(busy), .done(done), .result(result)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) q_m <= '0;
    else q_m <= (ctrl == 2'b11) ? d : (ctrl == 2'b01) ? q_m >> 1 : (ctrl == 2'b10) ? q_m << 1 : q_m;
  always @(negedge clk)
    if (!reset && done) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done result=%h", result);
      end else begin
        mon_exp = sb.pop_front();
        if (result !== mon_exp) begin
          bad++;
          $display("FAIL result got=%h exp=%h", result, mon_exp);
        end
      end
    end
  task automatic start(input logic [1:0] op, input logic [W-1:0] data, input logic [C-1:0] cnt, input bit push);
    logic [W-1:0] e;
    e = (op == 2'd0) ? data : (op == 2'd1) ? data >> cnt : (op == 2'd2) ? data << cnt : q_m;
    if (push) sb.push_back(e);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL cmd_ready got=%b exp=1", cmd_ready); end
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = cnt;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = W'($urandom); cmd_count = C'($urandom);
    if (op != 2'd3) last_d = data;
  endtask
  task automatic track(input logic [1:0] op, input logic [C-1:0] cnt, input int abort_at);
    int lat, eff;
    logic [1:0] ec;
    logic [W-1:0] r;
    lat = (op == 2'd3) ? 2 + int'(cnt) : (op == 2'd0) ? 3 : 3 + int'(cnt);
    eff = (op == 2'd0) ? 0 : int'(cnt);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      ec = (op == 2'd3) ? 2'd0 : (k == 1) ? 2'd3 : (k <= 1 + eff) ? op : 2'd0;
      total++;
      if (ctrl !== ec) begin bad++; $display("FAIL ctrl cyc=%0d got=%b exp=%b", k, ctrl, ec); end
      total++;
      if (done !== (k == lat)) begin bad++; $display("FAIL done cyc=%0d got=%b exp=%b", k, done, k == lat); end
      total++;
      if (busy !== (k < lat)) begin bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", k, busy, k < lat); end
      total++;
      if (d !== last_d) begin bad++; $display("FAIL d cyc=%0d got=%h exp=%h", k, d, last_d); end
      if (k == abort_at) begin
        r = result;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        total++;
        if (ctrl !== 2'b00 || busy !== 1'b0 || result !== r) begin
          bad++;
          $display("FAIL abort ctrl=%b busy=%b result=%h exp ctrl=00 busy=0 result=%h", ctrl, busy, result, r);
        end
        for (int j = 0; j < lat; j++) begin
          @(negedge clk);
          total++;
          if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
        end
        return;
      end
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (ctrl !== 2'b00 || d !== '0 || result !== '0 || done !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("FAIL reset ctrl=%b d=%h result=%h done=%b busy=%b exp all zero", ctrl, d, result, done, busy); end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL post_reset ready=%b busy=%b exp 1/0", cmd_ready, busy); end
  endtask
  task automatic test_shift_right();
    @(negedge clk);
    start(2'd1, 4'b1001, 3'd2, 1'b1);
    track(2'd1, 3'd2, 0);
  endtask
  task automatic test_shift_left();
    @(negedge clk);
    start(2'd2, 4'b1001, 3'd1, 1'b1);
    track(2'd2, 3'd1, 0);
  endtask
  task automatic test_load_only();
    @(negedge clk);
    start(2'd0, 4'b0110, 3'd5, 1'b1);
    track(2'd0, 3'd5, 0);
  endtask
  task automatic test_hold();
    @(negedge clk);
    start(2'd3, 4'b1111, 3'd0, 1'b1);
    track(2'd3, 3'd0, 0);
    @(negedge clk);
    start(2'd3, 4'b0001, 3'd7, 1'b1);
    track(2'd3, 3'd7, 0);
  endtask
  task automatic test_abort();
    @(negedge clk);
    start(2'd1, 4'b1011, 3'd5, 1'b0);
    track(2'd1, 3'd5, 3);
  endtask
  task automatic test_back_to_back();
    @(negedge clk);
    start(2'd1, 4'b1111, 3'd1, 1'b1);
    track(2'd1, 3'd1, 0);
    start(2'd2, 4'b0011, 3'd2, 1'b1);
    track(2'd2, 3'd2, 0);
    start(2'd0, 4'b1010, 3'd0, 1'b1);
    track(2'd0, 3'd0, 0);
    start(2'd3, 4'b0000, 3'd2, 1'b1);
    track(2'd3, 3'd2, 0);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] op;
      logic [W-1:0] dat;
      logic [C-1:0] cnt;
      op = 2'($urandom); dat = W'($urandom); cnt = C'($urandom);
      start(op, dat, cnt, 1'b1);
      track(op, cnt, 0);
    end
  endtask
  task automatic test_async_reset();
    @(negedge clk);
    start(2'd1, 4'b1101, 3'd5, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (ctrl !== 2'b00 || d !== '0 || result !== '0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1)
      begin bad++; $display("FAIL async_reset ctrl=%b d=%h result=%h done=%b busy=%b ready=%b", ctrl, d, result, done, busy, cmd_ready); end
    @(negedge clk);
    reset = 1'b0;
    last_d = '0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_discard done=%b busy=%b exp 0/0", done, busy); end
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
  endtask
  initial begin
    test_reset();
    test_shift_right();
    test_shift_left();
    test_load_only();
    test_hold();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
